// File: rtl/codec_cmm_sad_acc_if.sv
// ---------------------------------------------------------------------------
// codec_cmm_sad_acc_if
// Bundles the sample stream and result signals of the SAD accumulator.
//   master : producer of samples / consumer of results (upstream + search ctl)
//   slave  : the accumulator itself
// Signals:
//   input_vld  - diff is valid this cycle
//   diff       - unsigned absolute difference sample (DW bits)
//   blk_abort  - discard the partially accumulated block
//   sof        - start of a new search (also discards the partial block)
//   sad_vld    - one-cycle pulse, block SAD ready
//   sad        - registered block SAD (SW bits)
//   min_sad    - smallest SAD seen in the current search (SW bits)
//   min_idx    - index of the block that produced min_sad (IW bits)
// ---------------------------------------------------------------------------
interface codec_cmm_sad_acc_if #(
  parameter int DW = 8,
  parameter int SW = 12,
  parameter int IW = 8
);
  logic          input_vld;
  logic [DW-1:0] diff;
  logic          blk_abort;
  logic          sof;
  logic          sad_vld;
  logic [SW-1:0] sad;
  logic [SW-1:0] min_sad;
  logic [IW-1:0] min_idx;

  modport master (
    output input_vld, diff, blk_abort, sof,
    input  sad_vld, sad, min_sad, min_idx
  );

  modport slave (
    input  input_vld, diff, blk_abort, sof,
    output sad_vld, sad, min_sad, min_idx
  );
endinterface

// File: rtl/codec_cmm_sad_acc.sv
// ---------------------------------------------------------------------------
// codec_cmm_sad_acc
// Sum-of-absolute-differences accumulator for block matching. Sums BLK_NUM
// accepted diff samples into one block SAD, pulses sad_vld one cycle after
// the last sample, and optionally tracks the minimum SAD of a search.
//
// Optional feature macro: CODEC_SAD_MIN_TRACK_EN
//   defined   -> search-minimum tracker (blk_idx, min_valid, min_sad, min_idx)
//   undefined -> min_sad and min_idx are tied to zero
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - codec_cmm_sad_acc_if.slave (input_vld, diff, blk_abort, sof,
//            sad_vld, sad, min_sad, min_idx)
//
// Parameters: DW sample width, BLK_NUM samples per block (2..256),
//   SW SAD width (must be >= DW + clog2(BLK_NUM) so acc never wraps),
//   IW block-index width.
// ---------------------------------------------------------------------------
module codec_cmm_sad_acc #(
  parameter int DW      = 8,
  parameter int BLK_NUM = 16,
  parameter int SW      = 12,
  parameter int IW      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  codec_cmm_sad_acc_if.slave    bus
);

  localparam int CW = $clog2(BLK_NUM);
  localparam logic [CW-1:0] LAST = CW'(BLK_NUM - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] acc;
  logic          sad_vld;
  logic [SW-1:0] sad;

  logic [SW-1:0] diff_ext;
  logic [SW-1:0] blk_sum;
  logic          kill;
  logic          take;
  logic          blk_done;

  assign diff_ext = {{(SW-DW){1'b0}}, bus.diff};
  assign blk_sum  = acc + diff_ext;
  // sof and blk_abort both drop the sample of the same cycle
  assign kill     = bus.sof | bus.blk_abort;
  assign take     = bus.input_vld & ~kill;
  assign blk_done = take & (cnt == LAST);

  // Block accumulation FSM with registered sad / sad_vld
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= {CW{1'b0}};
      acc     <= {SW{1'b0}};
      sad     <= {SW{1'b0}};
      sad_vld <= 1'b0;
    end else begin
      sad_vld <= 1'b0;
      if (kill) begin
        state <= IDLE;
        cnt   <= {CW{1'b0}};
        acc   <= {SW{1'b0}};
      end else if (blk_done) begin
        // last sample: publish and clear in the same edge so the next block
        // can start on the very next cycle
        sad     <= blk_sum;
        sad_vld <= 1'b1;
        state   <= IDLE;
        cnt     <= {CW{1'b0}};
        acc     <= {SW{1'b0}};
      end else if (take) begin
        case (state)
          IDLE:    acc <= diff_ext;
          ACC:     acc <= blk_sum;
          default: acc <= blk_sum;
        endcase
        cnt   <= cnt + CW'(1);
        state <= ACC;
      end else begin
        state <= state;
        cnt   <= cnt;
        acc   <= acc;
      end
    end
  end

  assign bus.sad_vld = sad_vld;
  assign bus.sad     = sad;

`ifdef CODEC_SAD_MIN_TRACK_EN
  logic [IW-1:0] blk_idx;
  logic          min_valid;
  logic [SW-1:0] min_sad;
  logic [IW-1:0] min_idx;

  // Search-minimum tracker; updates on the same edge as sad
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_idx   <= {IW{1'b0}};
      min_valid <= 1'b0;
      min_sad   <= {SW{1'b0}};
      min_idx   <= {IW{1'b0}};
    end else if (bus.sof) begin
      // min_sad/min_idx intentionally hold until the next completed block
      blk_idx   <= {IW{1'b0}};
      min_valid <= 1'b0;
    end else if (blk_done) begin
      // strict less-than: the earliest block wins a tie
      if (!min_valid || (blk_sum < min_sad)) begin
        min_sad <= blk_sum;
        min_idx <= blk_idx;
      end else begin
        min_sad <= min_sad;
        min_idx <= min_idx;
      end
      min_valid <= 1'b1;
      blk_idx   <= blk_idx + IW'(1);
    end else begin
      blk_idx   <= blk_idx;
      min_valid <= min_valid;
    end
  end

  assign bus.min_sad = min_sad;
  assign bus.min_idx = min_idx;
`else
  assign bus.min_sad = {SW{1'b0}};
  assign bus.min_idx = {IW{1'b0}};
`endif

endmodule

// File: doc/codec_cmm_sad_acc.md
CODEC_CMM_SAD_ACC -- requirements
Module: codec_cmm_sad_acc

Interface
REQ-001 SHALL have parameter DW, default 8, width of each absolute-difference sample.
REQ-002 SHALL have parameter BLK_NUM, default 16, samples per block (legal range 2..256).
REQ-003 SHALL have parameter SW, default 12, SAD width, constrained to SW >= DW+ceil(log2(BLK_NUM)).
REQ-004 SHALL have parameter IW, default 8, block-index width.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port input_vld  input  1  diff is valid this cycle.
REQ-008 SHALL have port diff  input  DW  unsigned absolute difference from the upstream abs-sub stage.
REQ-009 SHALL have port blk_abort  input  1  synchronous pulse that discards the partial block.
REQ-010 SHALL have port sof  input  1  start-of-search pulse.
REQ-011 SHALL have port sad_vld  output  1  one-cycle pulse when a block SAD is ready.
REQ-012 SHALL have port sad  output  SW  registered block SAD.
REQ-013 SHALL have port min_sad  output  SW  smallest SAD in the current search.
REQ-014 SHALL have port min_idx  output  IW  index of the block that produced min_sad.

Function
REQ-015 SHALL use two states: IDLE (cnt==0, acc==0) and ACC (0<cnt<BLK_NUM).
- IDLE->ACC on accepted input_vld.
- ACC->IDLE on the BLK_NUM-th accepted sample, or on blk_abort/sof.
REQ-016 SHALL, on each accepted input_vld, set acc <= acc + zero-extended diff and cnt <= cnt+1.
REQ-017 SHALL, on the sample accepted at cnt==BLK_NUM-1:
- register sad <= acc+diff;
- assert sad_vld exactly one cycle later (latency 1);
- clear acc and cnt in the same edge.
REQ-018 SHALL accept a back-to-back next block, with sample 0 of block k+1 on the cycle after the last sample of block k, with no bubble.
REQ-019 SHALL hold acc, cnt and state unchanged during input_vld gaps of any length.
REQ-020 SHALL hold sad between sad_vld pulses; sad_vld SHALL be 0 otherwise.
REQ-021 SHALL give blk_abort priority over input_vld in the same cycle:
- the sample is dropped;
- acc and cnt clear;
- no sad_vld is produced.
REQ-022 SHALL treat sof the same as blk_abort for the partial block and, additionally, reset the search tracker (REQ-030).
REQ-023 SHALL never overflow acc, given REQ-003; the arithmetic is unsigned with no saturation.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force sad_vld=0, sad=0, min_sad=0, min_idx=0, acc=0, cnt=0, blk_idx=0, min_valid=0, state=IDLE.
REQ-025 SHALL discard a block that is partially accumulated when reset asserts; the first post-reset sample is sample 0.
REQ-026 SHALL accept input on the first clock edge after rst_n deasserts.

Configuration
REQ-027 SHALL compile the search-minimum tracker only when macro CODEC_SAD_MIN_TRACK_EN is defined.
REQ-028 SHALL, without the macro, keep ports min_sad and min_idx and tie them to 0; blk_idx and min_valid SHALL be absent.
REQ-029 SHALL, with the macro, increment blk_idx (wrapping at 2^IW) on every completed block.
REQ-030 SHALL, with the macro, on sof clear blk_idx to 0 and min_valid to 0; min_sad and min_idx hold until the next update.
REQ-031 SHALL, with the macro, on a completed block, load min_sad <= new SAD and min_idx <= blk_idx if min_valid==0 or new SAD < min_sad (strict, so the first minimum wins ties), then set min_valid=1.
REQ-032 SHALL, with the macro, update min_sad and min_idx on the same edge that updates sad; they are visible with sad_vld.

Verification (BLK_NUM=4, DW=8, SW=12 unless stated)
REQ-033 SHALL cover: diff 1,2,3,4 on consecutive cycles -> sad_vld=1 on the cycle after diff=4, with sad=10.
REQ-034 SHALL cover: BLK_NUM=16, diff=255 x16 -> sad=4080 with no overflow; the following block of all-zero diffs -> sad=0.
REQ-035 SHALL cover: diff 5,_,_,6,7,_,8 (underscore = input_vld low) -> a single sad_vld with sad=26; then back-to-back blocks 1,1,1,1,2,2,2,2 -> pulses at cycles 5 and 9 with sad=4 then 8.
REQ-036 SHALL cover: diff 9,9 then blk_abort concurrent with diff=9 -> no pulse; following 1,1,1,1 -> sad=4.
REQ-037 SHALL cover: rst_n low after 3 samples -> all outputs 0; after release, 2,2,2,2 -> sad=8.
REQ-038 SHALL cover, with CODEC_SAD_MIN_TRACK_EN: sof, then block sums 10,6,6,9 -> min_sad=6, min_idx=1; sof then a sum of 20 -> min_sad=20, min_idx=0; without the macro, min_sad and min_idx stay 0.
